// File: rtl/load_store_unit.sv
// Single-request MEM-stage initiator for a word-addressed memory. Sub-word stores
// are done as read-modify-write; loads return sign/zero-extended data.
module load_store_unit #(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned AW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_store,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_misalign,
  output logic          stall,
  output logic [AW-1:0] addr,
  output logic [31:0]   memWriteData,
  output logic          memRead,
  output logic          memWrite,
  input  logic [31:0]   readData
);

  localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(MEM_LAT - 1);

  typedef enum logic [2:0] {StIdle, StRd, StGap, StWr, StResp} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          store_q, store_d;
  logic [1:0]    size_q, size_d;
  logic          signed_q, signed_d;
  logic [1:0]    lane_q, lane_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          resp_misalign_q, resp_misalign_d;
  logic          req_ready_q, req_ready_d;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return (size == 2'b11) || (size == 2'b01 && a[0]) || (size == 2'b10 && a != 2'b00);
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                          input logic [1:0] lane, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    unique case (size)
      2'b00:   return sgn ? {{24{b[7]}}, b} : {24'b0, b};
      2'b01:   return sgn ? {{16{h[15]}}, h} : {16'b0, h};
      default: return word;
    endcase
  endfunction

  // Little-endian lane replacement of the captured word.
  function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] wd,
                                        input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] w;
    w = word;
    unique case (size)
      2'b00:   w[{lane, 3'b000} +: 8] = wd[7:0];
      2'b01:   w[{lane[1], 4'b0000} +: 16] = wd[15:0];
      default: w = wd;
    endcase
    return w;
  endfunction

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    store_d         = store_q;
    size_d          = size_q;
    signed_d        = signed_q;
    lane_d          = lane_q;
    wdata_d         = wdata_q;
    rdata_d         = rdata_q;
    addr_d          = addr_q;
    mem_wdata_d     = mem_wdata_q;
    resp_rdata_d    = 32'b0;
    resp_misalign_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          store_d  = req_store;
          size_d   = req_size;
          signed_d = req_signed;
          lane_d   = req_addr[1:0];
          wdata_d  = req_wdata;
          addr_d   = {req_addr[AW-1:2], 2'b00};
          cnt_d    = '0;
          if (misaligned(req_size, req_addr[1:0])) begin
            state_d         = StResp;
            resp_misalign_d = 1'b1;
          end else if (req_store && req_size == 2'b10) begin
            state_d     = StWr;
            mem_wdata_d = req_wdata;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: begin
        if (cnt_q == LastCnt) begin
          rdata_d = readData;
          cnt_d   = '0;
          if (store_q) begin
            state_d = StGap;
          end else begin
            state_d      = StResp;
            resp_rdata_d = extract(readData, size_q, lane_q, signed_q);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StGap: begin
        state_d     = StWr;
        cnt_d       = '0;
        mem_wdata_d = merge(rdata_q, wdata_q, size_q, lane_q);
      end
      StWr: begin
        if (cnt_q == LastCnt) begin
          state_d = StResp;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Strobes and handshakes are registered from the next state.
    mem_read_d   = (state_d == StRd);
    mem_write_d  = (state_d == StWr);
    resp_valid_d = (state_d == StResp);
    req_ready_d  = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      store_q         <= 1'b0;
      size_q          <= 2'b00;
      signed_q        <= 1'b0;
      lane_q          <= 2'b00;
      wdata_q         <= 32'b0;
      rdata_q         <= 32'b0;
      addr_q          <= '0;
      mem_wdata_q     <= 32'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= 32'b0;
      resp_misalign_q <= 1'b0;
      req_ready_q     <= 1'b1;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      store_q         <= store_d;
      size_q          <= size_d;
      signed_q        <= signed_d;
      lane_q          <= lane_d;
      wdata_q         <= wdata_d;
      rdata_q         <= rdata_d;
      addr_q          <= addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      resp_valid_q    <= resp_valid_d;
      resp_rdata_q    <= resp_rdata_d;
      resp_misalign_q <= resp_misalign_d;
      req_ready_q     <= req_ready_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign stall         = ~req_ready_q;
  assign addr          = addr_q;
  assign memWriteData  = mem_wdata_q;
  assign memRead       = mem_read_q;
  assign memWrite      = mem_write_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_misalign = resp_misalign_q;

endmodule
